fadd_issue: RTL and testbench

- Issue/collect wrapper that sits directly around the pipelined single-precision adder `fadd`.
- Upstream side: accepts tagged operand pairs over a valid/ready handshake and registers them onto fadd's x1/x2 inputs.
- Downstream side: tracks each operation through fadd's fixed latency, then captures fadd's y with its tag into a small result FIFO drained by valid/ready.
- Credit-based issue guarantees the FIFO never overflows, even under sustained backpressure.

---
 rtl/fadd_issue.sv | 126 ++++++++++++
 tb/tb_fadd_issue.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_issue.sv
// Issue/collect wrapper around a fixed-latency pipelined FP adder: registers
// tagged operands into the adder, tracks them through its latency and buffers results.
module fadd_issue #(
  parameter int FADD_LAT = 2,
  parameter int TAG_W    = 4,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fadd_x1,
  output logic [31:0]      fadd_x2,
  input  logic [31:0]      fadd_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(DEPTH);

  logic accept;
  logic push;
  logic pop;

  // Operand registers feeding the adder
  logic [31:0] x1_q, x1_d;
  logic [31:0] x2_q, x2_d;

  // Tracking shift register: stage gi holds the token issued gi edges ago
  logic [FADD_LAT:0] trk_vld_q, trk_vld_d;
  logic [TAG_W-1:0]  trk_tag_q [FADD_LAT+1];
  logic [TAG_W-1:0]  trk_tag_d [FADD_LAT+1];

  // Result FIFO storage and control
  logic [31:0]      mem_y_q   [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits come from registered occupancy only, so there is no path from out_ready
  assign in_ready  = !rst && (occ_q < OCC_MAX);
  assign accept    = in_valid && in_ready;
  assign out_valid = !rst && (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = trk_vld_q[FADD_LAT];
  assign busy      = !rst && (occ_q != '0);

  assign fadd_x1 = x1_q;
  assign fadd_x2 = x2_q;
  assign out_y   = mem_y_q[rd_ptr_q];
  assign out_tag = mem_tag_q[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi <= FADD_LAT; gi++) begin : g_trk
      if (gi == 0) begin : g_head
        assign trk_vld_d[gi] = accept;
        assign trk_tag_d[gi] = in_tag;
      end else begin : g_shift
        assign trk_vld_d[gi] = trk_vld_q[gi-1];
        assign trk_tag_d[gi] = trk_tag_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    x1_d = x1_q;
    x2_d = x2_q;
    if (accept) begin
      x1_d = in_x1;
      x2_d = in_x2;
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + OCC_W'(push) - OCC_W'(pop);
    occ_d    = occ_q + OCC_W'(accept) - OCC_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q      <= '0;
      x2_q      <= '0;
      trk_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      occ_q     <= '0;
    end else begin
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      trk_vld_q <= trk_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      occ_q     <= occ_d;
    end
  end

  // Tags and storage carry no reset; validity lives in trk_vld_q and cnt_q
  always_ff @(posedge clk) begin
    trk_tag_q <= trk_tag_d;
    if (push) begin
      mem_y_q[wr_ptr_q]   <= fadd_y;
      mem_tag_q[wr_ptr_q] <= trk_tag_q[FADD_LAT];
    end
  end

endmodule

// File: tb/tb_fadd_issue.sv
// Bench for fadd_issue: a stand-in pipelined adder, a queue-based reference
// model of accepted operations, directed scenarios and a randomized run.
module tb_fadd_issue;
  localparam int FADD_LAT = 2;
  localparam int TAG_W    = 4;
  localparam int DEPTH    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fadd_x1;
  logic [31:0]      fadd_x2;
  logic [31:0]      fadd_y;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  fadd_issue #(.FADD_LAT(FADD_LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .busy(busy)
  );

  // Known IEEE sums for the directed pairs; other pairs map to a scrambled word
  function automatic logic [31:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40400000_C0400000: return 32'h00000000;
      64'h4048F5C3_40000000: return 32'h40A47AE1;
      64'h3F800000_3F8CCCCD: return 32'h40066666;
      64'h40200000_40000000: return 32'h40900000;
      64'h40400000_C37F0000: return 32'hC37C0000;
      64'h00000000_00000000: return 32'h00000000;
      default:               return a ^ {b[15:0], b[31:16]} ^ 32'h13579BDF;
    endcase
  endfunction

  // Stand-in adder with two pipeline registers
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    p1 <= fadd_ref(fadd_x1, fadd_x2);
    p2 <= p1;
  end
  assign fadd_y = p2;

  // Reference model: every accepted op becomes visible FADD_LAT+1 edges later
  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    int               rdy;
  } res_t;
  res_t mq[$];

  always @(posedge clk) begin
    int  sz;
    bit  ov;
    cyc++;
    if (rst) begin
      mq.delete();
    end else begin
      sz = mq.size();
      ov = (sz > 0) && (mq[0].rdy <= cyc - 1);
      if (in_valid && sz < DEPTH)
        mq.push_back('{fadd_ref(in_x1, in_x2), in_tag, cyc + FADD_LAT + 1});
      if (ov && out_ready)
        void'(mq.pop_front());
    end
  end

  function automatic bit m_ov();
    return (mq.size() > 0) && (mq[0].rdy <= cyc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input int t);
    in_valid = 1'b1;
    in_x1    = a;
    in_x2    = b;
    in_tag   = TAG_W'(t);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); else passed++;
    checks++; if ({fadd_x1, fadd_x2} !== 64'h0) $display("FAIL reset_fadd_x got=%h_%h exp=0_0", fadd_x1, fadd_x2); else passed++;
    tick();
  endtask

  task automatic test_single();
    int lat;
    out_ready = 1'b1;
    set_op(32'h40400000, 32'hC0400000, 1);
    tick();
    in_valid = 1'b0;
    for (lat = 0; lat < 10 && !out_valid; lat++) tick();
    checks++; if (lat !== FADD_LAT + 1) $display("FAIL single_latency got=%0d exp=%0d", lat, FADD_LAT + 1); else passed++;
    checks++; if (out_y !== 32'h00000000 || out_tag !== 4'd1)
      $display("FAIL single_result got=%h/%0d exp=00000000/1", out_y, out_tag); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL single_busy_before_pop got=%0b exp=1", busy); else passed++;
    tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL single_after_pop got busy=%0b valid=%0b exp=0/0", busy, out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa [4] = '{32'h4048F5C3, 32'h3F800000, 32'h40200000, 32'h40400000};
    logic [31:0] xb [4] = '{32'h40000000, 32'h3F8CCCCD, 32'h40000000, 32'hC37F0000};
    logic [31:0] ey [4] = '{32'h40A47AE1, 32'h40066666, 32'h40900000, 32'hC37C0000};
    int got = 0;
    int prev = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(xa[i], xb[i], i + 2);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      if (out_valid) begin
        checks++; if (out_y !== ey[got] || out_tag !== TAG_W'(got + 2))
          $display("FAIL b2b_result[%0d] got=%h/%0d exp=%h/%0d", got, out_y, out_tag, ey[got], got + 2); else passed++;
        if (got > 0) begin
          checks++; if (cyc - prev !== 1) $display("FAIL b2b_gap[%0d] got=%0d exp=1", got, cyc - prev); else passed++;
        end
        prev = cyc;
        got++;
      end
      tick();
    end
    checks++; if (got !== 4) $display("FAIL b2b_count got=%0d exp=4", got); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] xa [6];
    logic [31:0] xb [6];
    logic [31:0] hy;
    logic [TAG_W-1:0] ht;
    int idx = 0;
    int got = 1;
    bit take;
    for (int i = 0; i < 6; i++) begin xa[i] = $urandom; xb[i] = $urandom; end
    out_ready = 1'b0;
    set_op(xa[0], xb[0], 8);
    for (int c = 0; c < 12; c++) begin
      take = in_ready;
      tick();
      if (take) begin idx++; set_op(xa[idx], xb[idx], idx + 8); end
    end
    checks++; if (idx !== DEPTH) $display("FAIL bp_accepted got=%0d exp=%0d", idx, DEPTH); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got=%0b exp=0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'd8 || out_y !== fadd_ref(xa[0], xb[0]))
      $display("FAIL bp_head got=%0b/%h/%0d exp=1/%h/8", out_valid, out_y, out_tag, fadd_ref(xa[0], xb[0])); else passed++;
    hy = out_y; ht = out_tag;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (out_y !== hy || out_tag !== ht || out_valid !== 1'b1)
        $display("FAIL bp_head_stable[%0d] got=%h/%0d exp=%h/%0d", c, out_y, out_tag, hy, ht); else passed++;
    end
    out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_after_pop got=%0b exp=1", in_ready); else passed++;
    for (int c = 0; c < 40 && got < 6; c++) begin
      take = in_valid && in_ready;
      if (out_valid) begin
        checks++; if (out_tag !== TAG_W'(got + 8) || out_y !== fadd_ref(xa[got], xb[got]))
          $display("FAIL bp_drain[%0d] got=%h/%0d exp=%h/%0d", got, out_y, out_tag, fadd_ref(xa[got], xb[got]), got + 8); else passed++;
        got++;
      end
      tick();
      if (take) begin
        idx++;
        if (idx < 6) set_op(xa[idx], xb[idx], idx + 8); else in_valid = 1'b0;
      end
    end
    checks++; if (got !== 6) $display("FAIL bp_drain_count got=%0d exp=6", got); else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_accept_pop();
    int got = 0;
    logic [TAG_W-1:0] et [3] = '{4'd2, 4'd3, 4'd4};
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin set_op($urandom, $urandom, i); tick(); end
    in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (in_ready !== 1'b1 || out_tag !== 4'd1)
      $display("FAIL ap_pre got ready=%0b tag=%0d exp=1/1", in_ready, out_tag); else passed++;
    set_op($urandom, $urandom, 4);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL ap_occ got ready=%0b busy=%0b exp=1/1", in_ready, busy); else passed++;
    checks++; if (out_tag !== 4'd2) $display("FAIL ap_head got=%0d exp=2", out_tag); else passed++;
    repeat (4) tick();
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got < 3; c++) begin
      if (out_valid) begin
        checks++; if (out_tag !== et[got]) $display("FAIL ap_drain[%0d] got=%0d exp=%0d", got, out_tag, et[got]); else passed++;
        got++;
      end
      tick();
    end
    checks++; if (got !== 3 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL ap_final got n=%0d valid=%0b busy=%0b exp=3/0/0", got, out_valid, busy); else passed++;
  endtask

  task automatic test_reset_midflight();
    int lat;
    out_ready = 1'b1;
    set_op(32'h4048F5C3, 32'h40000000, 5); tick();
    set_op(32'h3F800000, 32'h3F8CCCCD, 6); tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rmf_state got valid=%0b busy=%0b exp=0/0", out_valid, busy); else passed++;
    checks++; if ({fadd_x1, fadd_x2} !== 64'h0) $display("FAIL rmf_fadd_x got=%h_%h exp=0_0", fadd_x1, fadd_x2); else passed++;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL rmf_stale[%0d] got=%0b exp=0", c, out_valid); else passed++;
    end
    set_op(32'h40200000, 32'h40000000, 7);
    tick();
    in_valid = 1'b0;
    for (lat = 0; lat < 10 && !out_valid; lat++) tick();
    checks++; if (out_y !== 32'h40900000 || out_tag !== 4'd7 || lat !== FADD_LAT + 1)
      $display("FAIL rmf_new got=%h/%0d lat=%0d exp=40900000/7 lat=%0d", out_y, out_tag, lat, FADD_LAT + 1); else passed++;
    tick();
  endtask

  task automatic test_zero_toggle();
    int issued = 0;
    int got = 0;
    bit take;
    for (int c = 0; c < 80 && got < 8; c++) begin
      if (issued < 8) set_op(32'h0, 32'h0, issued); else in_valid = 1'b0;
      out_ready = c[0];
      take = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checks++; if (out_y !== 32'h0 || out_tag !== TAG_W'(got))
          $display("FAIL zero_result[%0d] got=%h/%0d exp=00000000/%0d", got, out_y, out_tag, got); else passed++;
        got++;
      end
      tick();
      if (take) issued++;
    end
    in_valid = 1'b0;
    checks++; if (got !== 8) $display("FAIL zero_count got=%0d exp=8", got); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      in_x1     = $urandom;
      in_x2     = $urandom;
      in_tag    = TAG_W'($urandom);
      checks++; if (in_ready !== (mq.size() < DEPTH))
        $display("FAIL rnd_in_ready[%0d] got=%0b exp=%0b", c, in_ready, mq.size() < DEPTH); else passed++;
      checks++; if (out_valid !== m_ov())
        $display("FAIL rnd_out_valid[%0d] got=%0b exp=%0b", c, out_valid, m_ov()); else passed++;
      checks++; if (busy !== (mq.size() != 0))
        $display("FAIL rnd_busy[%0d] got=%0b exp=%0b", c, busy, mq.size() != 0); else passed++;
      if (m_ov()) begin
        checks++; if (out_y !== mq[0].y || out_tag !== mq[0].tag)
          $display("FAIL rnd_head[%0d] got=%h/%0d exp=%h/%0d", c, out_y, out_tag, mq[0].y, mq[0].tag); else passed++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL rnd_drained got busy=%0b valid=%0b exp=0/0", busy, out_valid); else passed++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x1 = '0; in_x2 = '0; in_tag = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_accept_pop();
    test_reset_midflight();
    test_zero_toggle();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
